// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: base opcodes, immediate formats, ID-stage FSM states
// and the immediate-assembly helpers used by id_stage.
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  typedef enum logic {ST_RUN = 1'b0, ST_BUBBLE = 1'b1} state_e;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_STORE, OP_OP,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: is_legal = 1'b1;
      default:                                       is_legal = 1'b0;
    endcase
  endfunction

  function automatic imm_type_e imm_type_of(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: imm_type_of = IMM_I;
      OP_STORE:                            imm_type_of = IMM_S;
      OP_BRANCH:                           imm_type_of = IMM_B;
      OP_LUI, OP_AUIPC:                    imm_type_of = IMM_U;
      OP_JAL:                              imm_type_of = IMM_J;
      default:                             imm_type_of = IMM_NONE;
    endcase
  endfunction

  function automatic logic [31:0] make_imm(input imm_type_e t, input logic [31:0] i);
    case (t)
      IMM_I:   make_imm = {{21{i[31]}}, i[30:20]};
      IMM_S:   make_imm = {{21{i[31]}}, i[30:25], i[11:7]};
      IMM_B:   make_imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   make_imm = {i[31:12], 12'h000};
      IMM_J:   make_imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      default: make_imm = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two async read ports, one clocked write port, x0 hard-wired to 0.
// Optional same-cycle write-back bypass on reads when WB_BYPASS_EN is defined.
module regfile (
  input  logic        clk,
  input  logic        rst_,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] regs [1:31];

  // NOTE: the array is reset explicitly because software may read any register before
  // writing it; this costs a reset net on every bit, so it cannot map to a RAM macro.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // NOTE: every path of a combinational block assigns a default first, so no latch is inferred.
  always_comb begin
    rdata_a = '0;
    if (raddr_a != 5'd0) begin
      rdata_a = regs[raddr_a];
`ifdef WB_BYPASS_EN
      if (we && (waddr == raddr_a)) rdata_a = wdata;
`endif
    end
  end

  always_comb begin
    rdata_b = '0;
    if (raddr_b != 5'd0) begin
      rdata_b = regs[raddr_b];
`ifdef WB_BYPASS_EN
      if (we && (waddr == raddr_b)) rdata_b = wdata;
`endif
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction decode stage: field/immediate decode, register read, illegal-opcode
// flag and a RUN/BUBBLE FSM that inserts one bubble on a load-use hazard. WB_BYPASS_EN selects
// same-cycle write-back forwarding inside the register file.
module id_stage
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic [4:0]  ex_rd_addr,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] imm,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        stall,
  output logic        illegal
);

  state_e state, state_next;
  logic   uses_rs1, uses_rs2, hazard, legal;

  assign opcode   = if_instr[6:0];
  assign rd_addr  = if_instr[11:7];
  assign func3    = if_instr[14:12];
  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];
  assign func7    = if_instr[31:25];
  assign id_pc    = if_pc;
  assign imm      = make_imm(imm_type_of(opcode), if_instr);

  assign legal    = is_legal(opcode);
  assign illegal  = rst_ & if_valid & ~legal;

  assign uses_rs1 = ~((opcode == OP_LUI) | (opcode == OP_AUIPC) | (opcode == OP_JAL));
  assign uses_rs2 = (opcode == OP_BRANCH) | (opcode == OP_STORE) | (opcode == OP_OP);

  assign hazard = if_valid & ex_valid & (ex_opcode == OP_LOAD) & (ex_rd_addr != 5'd0) &
                  ((uses_rs1 & (ex_rd_addr == rs1_addr)) | (uses_rs2 & (ex_rd_addr == rs2_addr)));

  regfile u_regfile (
    .clk     (clk),
    .rst_    (rst_),
    .we      (wb_we),
    .waddr   (wb_rd_addr),
    .wdata   (wb_data),
    .raddr_a (rs1_addr),
    .raddr_b (rs2_addr),
    .rdata_a (rs1_data),
    .rdata_b (rs2_data)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= ST_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:    if (hazard) state_next = ST_BUBBLE;
      ST_BUBBLE: state_next = ST_RUN;
      default:   state_next = ST_RUN;
    endcase
    if (flush) state_next = ST_RUN;
  end

  // Flush wins over the hazard stall; outputs are held low while reset is asserted.
  always_comb begin
    stall    = 1'b0;
    id_valid = if_valid & ~illegal;
    if ((state == ST_RUN) && hazard) begin
      stall    = 1'b1;
      id_valid = 1'b0;
    end
    if (flush || !rst_) begin
      stall    = 1'b0;
      id_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: the stimulus process queues expected output values and
// a monitor on the falling clock edge pops and compares them.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_;
  logic        if_valid, flush, ex_valid, wb_we;
  logic [31:0] if_pc, if_instr, wb_data;
  logic [6:0]  ex_opcode;
  logic [4:0]  ex_rd_addr, wb_rd_addr;
  logic        id_valid, stall, illegal;
  logic [31:0] id_pc, imm, rs1_data, rs2_data;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_(rst_), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .flush(flush), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd_addr(ex_rd_addr),
    .wb_we(wb_we), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .imm(imm), .opcode(opcode), .func3(func3),
    .func7(func7), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .stall(stall), .illegal(illegal)
  );

  typedef enum int {F_VALID, F_STALL, F_ILL, F_OPC, F_RD, F_RS1, F_RS2, F_F3,
                    F_IMM, F_PC, F_D1, F_D2} field_e;

  typedef struct {
    string       name;
    field_e      sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [6:0] LOAD = 7'b0000011;
`ifdef WB_BYPASS_EN
  localparam logic [31:0] SAME_CYCLE_X5 = 32'hDEADBEEF;
`else
  localparam logic [31:0] SAME_CYCLE_X5 = 32'h0;
`endif

  function automatic logic [31:0] field(input field_e s);
    case (s)
      F_VALID: field = {31'd0, id_valid};
      F_STALL: field = {31'd0, stall};
      F_ILL:   field = {31'd0, illegal};
      F_OPC:   field = {25'd0, opcode};
      F_RD:    field = {27'd0, rd_addr};
      F_RS1:   field = {27'd0, rs1_addr};
      F_RS2:   field = {27'd0, rs2_addr};
      F_F3:    field = {29'd0, func3};
      F_IMM:   field = imm;
      F_PC:    field = id_pc;
      F_D1:    field = rs1_data;
      F_D2:    field = rs2_data;
      default: field = 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_val(input string name, input field_e sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd);
    ex_valid   = v;
    ex_opcode  = LOAD;
    ex_rd_addr = rd;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = field(e.sel);
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.exp, $time);
      end
    end
  end

  initial begin
    rst_ = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd_addr = '0; wb_data = '0;
    set_ex(1'b0, 5'd0);
    if_valid = 1'b1; if_pc = 32'h0; if_instr = 32'h007380B3;  // add x1,x7,x7
    expect_val("rst_valid", F_VALID, 0);
    expect_val("rst_stall", F_STALL, 0);
    expect_val("rst_illegal", F_ILL, 0);
    expect_val("rst_rs1_data", F_D1, 0);
    expect_val("rst_rs2_data", F_D2, 0);
    expect_val("rst_rs1_addr", F_RS1, 7);
    #12 rst_ = 1'b1;

    cycle();  // addi x3,x0,4 with an ex LOAD to x0 (never a hazard)
    set_ex(1'b1, 5'd0);
    if_pc = 32'h10; if_instr = 32'h00400193;
    expect_val("addi_opcode", F_OPC, 32'h13);
    expect_val("addi_rd", F_RD, 3);
    expect_val("addi_rs1", F_RS1, 0);
    expect_val("addi_imm", F_IMM, 4);
    expect_val("addi_pc", F_PC, 32'h10);
    expect_val("addi_valid", F_VALID, 1);
    expect_val("addi_stall", F_STALL, 0);

    cycle();  // addi x1,x0,-1
    set_ex(1'b0, 5'd0);
    if_instr = 32'hFFF00093;
    expect_val("addi_neg_imm", F_IMM, 32'hFFFFFFFF);

    cycle();  // sw x2,8(x1)
    if_instr = 32'h0020A423;
    expect_val("sw_imm", F_IMM, 8);
    expect_val("sw_func3", F_F3, 2);
    expect_val("sw_rs2", F_RS2, 2);

    cycle();  // jal x1,8
    if_instr = 32'h008000EF;
    expect_val("jal_imm", F_IMM, 8);

    cycle();  // lui x1,0x8 (rs1 field = 1 but unused) against ex LOAD x1
    set_ex(1'b1, 5'd1);
    if_instr = 32'h000080B7;
    expect_val("lui_imm", F_IMM, 32'h00008000);
    expect_val("lui_no_stall", F_STALL, 0);
    expect_val("lui_valid", F_VALID, 1);

    cycle();  // write x5 while reading it
    set_ex(1'b0, 5'd0);
    if_instr = 32'h00528333;  // add x6,x5,x5
    wb_we = 1'b1; wb_rd_addr = 5'd5; wb_data = 32'hDEADBEEF;
    expect_val("x5_same_cycle", F_D1, SAME_CYCLE_X5);

    cycle();  // x5 reads back; coincident write to x0 must not show up
    if_instr = 32'h00028333;  // add x6,x5,x0
    wb_rd_addr = 5'd0; wb_data = 32'h12345678;
    expect_val("x5_readback", F_D1, 32'hDEADBEEF);
    expect_val("x0_during_write", F_D2, 0);

    cycle();
    wb_we = 1'b0;
    if_instr = 32'h00000333;  // add x6,x0,x0
    expect_val("x0_after_write", F_D1, 0);

    cycle();  // load-use hazard, WB write to x9 in the same cycle
    set_ex(1'b1, 5'd1);
    if_instr = 32'h00108133;  // add x2,x1,x1
    wb_we = 1'b1; wb_rd_addr = 5'd9; wb_data = 32'hA5A5A5A5;
    expect_val("hz_stall", F_STALL, 1);
    expect_val("hz_valid", F_VALID, 0);
    expect_val("hz_op_imm", F_IMM, 0);

    cycle();  // BUBBLE: hazard ignored
    wb_we = 1'b0;
    expect_val("bubble_stall", F_STALL, 0);
    expect_val("bubble_valid", F_VALID, 1);

    cycle();
    set_ex(1'b0, 5'd0);
    if_instr = 32'h00048133;  // add x2,x9,x0
    expect_val("x9_written_in_stall", F_D1, 32'hA5A5A5A5);
    expect_val("run_valid", F_VALID, 1);

    cycle();  // flush in a hazard cycle
    set_ex(1'b1, 5'd1);
    if_instr = 32'h00108133;
    flush = 1'b1;
    expect_val("flush_stall", F_STALL, 0);
    expect_val("flush_valid", F_VALID, 0);

    cycle();  // flush left the FSM in RUN, so the hazard stalls now
    flush = 1'b0;
    expect_val("after_flush_stall", F_STALL, 1);

    cycle();  // flush while in BUBBLE
    flush = 1'b1;
    expect_val("bubble_flush_valid", F_VALID, 0);
    expect_val("bubble_flush_stall", F_STALL, 0);

    cycle();
    flush = 1'b0;
    set_ex(1'b0, 5'd0);
    if_instr = 32'hFE000EE3;  // beq x0,x0,-4
    expect_val("beq_imm", F_IMM, 32'hFFFFFFFC);
    expect_val("beq_opcode", F_OPC, 32'h63);
    expect_val("beq_valid", F_VALID, 1);

    cycle();
    if_instr = 32'h0000007F;
    expect_val("illegal_flag", F_ILL, 1);
    expect_val("illegal_valid", F_VALID, 0);

    cycle();  // hazard from RUN -> BUBBLE on the next edge
    set_ex(1'b1, 5'd1);
    if_instr = 32'h00108133;
    expect_val("pre_reset_stall", F_STALL, 1);

    cycle();  // reset pulse while in BUBBLE returns to RUN, so the hazard stalls again
    rst_ = 1'b0;
    #1 rst_ = 1'b1;
    expect_val("reset_in_bubble_stall", F_STALL, 1);

    cycle();
    set_ex(1'b0, 5'd0);
    if_instr = 32'h00528333;
    expect_val("x5_cleared_by_reset", F_D1, 0);
    expect_val("bubble_after_reset_valid", F_VALID, 1);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
